// File: rtl/code_sel_pkg.sv
// Shared definitions for the code emitter and the block that receives its codes.
package code_sel_pkg;

   localparam int unsigned NUM_CODES = 18;
   localparam int unsigned CODE_W    = 6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OFFER = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   // Code k (1..NUM_CODES) maps to bit k-1; code 0 or out-of-range codes map to zero.
   function automatic logic [NUM_CODES-1:0] code_to_onehot(input logic [CODE_W-1:0] code);
      logic [NUM_CODES-1:0] oh;
      oh = '0;
      if ((code != '0) && (32'(code) <= NUM_CODES)) begin
         oh = NUM_CODES'(1) << (code - CODE_W'(1));
      end
      return oh;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping at N-1.
module rr_pick #(
   parameter int unsigned N  = 18,
   parameter int unsigned IW = 5
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] idx,
   output logic          found
);

   // Scan N positions starting at ptr; the first hit wins.
   always_comb begin
      int unsigned j;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int unsigned i = 0; i < N; i++) begin
         j = 32'(ptr) + i;
         if (j >= N) begin
            j = j - N;
         end
         if (!found && req[j]) begin
            found = 1'b1;
            idx   = IW'(j);
         end
      end
   end

endmodule

// File: rtl/code_emitter.sv
// Collects per-source requests and emits their codes one at a time over a
// valid/ready handshake, with round-robin fairness and an idle gap between codes.
module code_emitter #(
   parameter int unsigned NUM_CODES  = code_sel_pkg::NUM_CODES,
   parameter int unsigned CODE_W     = code_sel_pkg::CODE_W,
   parameter int unsigned GAP_CYCLES = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic [NUM_CODES-1:0] req_i,
   input  logic                 flush_i,
   output logic [CODE_W-1:0]    data_o,
   output logic                 data_val_o,
   input  logic                 data_rdy_i,
   output logic [NUM_CODES-1:0] pending_o,
   output logic                 busy_o
);

   import code_sel_pkg::*;

   localparam int unsigned IW    = (NUM_CODES > 1) ? $clog2(NUM_CODES) : 1;
   localparam int unsigned GAP_W = 4;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   state_t               state_q;
   logic [NUM_CODES-1:0] pending_q;
   logic [NUM_CODES-1:0] pending_d;
   logic [IW-1:0]        rr_ptr;
   logic [IW-1:0]        cur_idx;
   logic [IW-1:0]        cur_nxt;
   logic [GAP_W-1:0]     gap_cnt;
   logic [NUM_CODES-1:0] cur_oh;
   logic [NUM_CODES-1:0] clr;
   logic                 xfer;
   logic [NUM_CODES-1:0] pick_vec;
   logic [IW-1:0]        pick_ptr;
   logic [IW-1:0]        pick_idx;
   logic                 pick_found;

   // Transfer decode, pending update and picker input selection.
   always_comb begin
      cur_oh    = NUM_CODES'(1) << cur_idx;
      cur_nxt   = (cur_idx == IW'(NUM_CODES - 1)) ? '0 : cur_idx + IW'(1);
      xfer      = data_val_o & data_rdy_i & ~flush_i;
      clr       = xfer ? cur_oh : '0;
      pending_d = flush_i ? '0 : ((pending_q & ~clr) | req_i);
      pick_vec  = pending_q;
      pick_ptr  = rr_ptr;
      if (state_q == ST_OFFER) begin
         // Back-to-back choice: skip the code on offer, search past it.
         pick_vec = pending_q & ~cur_oh;
         pick_ptr = cur_nxt;
      end
   end

   rr_pick #(
      .N  (NUM_CODES),
      .IW (IW)
   ) u_rr_pick (
      .req   (pick_vec),
      .ptr   (pick_ptr),
      .idx   (pick_idx),
      .found (pick_found)
   );

   // Emitter FSM with registered offer outputs; flush overrides everything.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= ST_IDLE;
         pending_q  <= '0;
         rr_ptr     <= '0;
         cur_idx    <= '0;
         gap_cnt    <= '0;
         data_o     <= '0;
         data_val_o <= 1'b0;
      end else begin
         pending_q <= pending_d;
         if (flush_i) begin
            state_q    <= ST_IDLE;
            gap_cnt    <= '0;
            data_o     <= '0;
            data_val_o <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (pick_found) begin
                     state_q    <= ST_OFFER;
                     cur_idx    <= pick_idx;
                     data_o     <= CODE_W'(pick_idx) + CODE_W'(1);
                     data_val_o <= 1'b1;
                  end
               end
               ST_OFFER: begin
                  if (xfer) begin
                     rr_ptr <= cur_nxt;
                     if (GAP_CYCLES > 0) begin
                        state_q    <= ST_GAP;
                        gap_cnt    <= '0;
                        data_o     <= '0;
                        data_val_o <= 1'b0;
                     end else if (pick_found) begin
                        cur_idx <= pick_idx;
                        data_o  <= CODE_W'(pick_idx) + CODE_W'(1);
                     end else begin
                        state_q    <= ST_IDLE;
                        data_o     <= '0;
                        data_val_o <= 1'b0;
                     end
                  end
               end
               ST_GAP: begin
                  if (gap_cnt == GAP_LAST) begin
                     gap_cnt <= '0;
                     if (pick_found) begin
                        state_q    <= ST_OFFER;
                        cur_idx    <= pick_idx;
                        data_o     <= CODE_W'(pick_idx) + CODE_W'(1);
                        data_val_o <= 1'b1;
                     end else begin
                        state_q <= ST_IDLE;
                     end
                  end else begin
                     gap_cnt <= gap_cnt + GAP_W'(1);
                  end
               end
               default: begin
                  state_q    <= ST_IDLE;
                  data_o     <= '0;
                  data_val_o <= 1'b0;
               end
            endcase
         end
      end
   end

   assign pending_o = pending_q;
   assign busy_o    = (state_q != ST_IDLE) || (|pending_q);

endmodule

// File: tb/tb_code_emitter.sv
// Directed bench for code_emitter with default parameters (18 codes, gap of 2).
module tb_code_emitter;

   logic        clk_i;
   logic        rst_n_i;
   logic [17:0] req_i;
   logic        flush_i;
   logic [5:0]  data_o;
   logic        data_val_o;
   logic        data_rdy_i;
   logic [17:0] pending_o;
   logic        busy_o;

   int checks = 0;
   int errors = 0;

   code_emitter dut (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .req_i      (req_i),
      .flush_i    (flush_i),
      .data_o     (data_o),
      .data_val_o (data_val_o),
      .data_rdy_i (data_rdy_i),
      .pending_o  (pending_o),
      .busy_o     (busy_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      int seen;
      int last;
      int exp3 [3];
      exp3 = '{10, 3, 7};

      rst_n_i    = 1'b0;
      req_i      = '0;
      flush_i    = 1'b0;
      data_rdy_i = 1'b1;

      // Reset values, before any clock edge
      #2;
      chk("rst_val", 32'(data_val_o), 0);
      chk("rst_data", 32'(data_o), 0);
      chk("rst_pending", 32'(pending_o), 0);
      chk("rst_busy", 32'(busy_o), 0);
      tick();
      tick();
      rst_n_i = 1'b1;
      tick();
      chk("post_rst_idle_val", 32'(data_val_o), 0);

      // Single request on bit 4 -> code 5 two edges later
      req_i = 18'h00010;
      tick();
      req_i = '0;
      chk("single_pending", 32'(pending_o), 32'h10);
      chk("single_val_early", 32'(data_val_o), 0);
      chk("single_busy", 32'(busy_o), 1);
      tick();
      chk("single_val", 32'(data_val_o), 1);
      chk("single_data", 32'(data_o), 5);
      tick();
      chk("single_val_drop", 32'(data_val_o), 0);
      chk("single_data_zero", 32'(data_o), 0);
      chk("single_pending_clr", 32'(pending_o), 0);
      tick();
      tick();
      chk("single_busy_end", 32'(busy_o), 0);

      // All requests at once from a fresh reset: 1..18, three cycles apart
      rst_n_i = 1'b0;
      tick();
      rst_n_i = 1'b1;
      tick();
      req_i = 18'h3FFFF;
      seen  = 0;
      last  = 0;
      for (int c = 0; c < 70; c++) begin
         tick();
         req_i = '0;
         if (data_val_o) begin
            chk("all_code", 32'(data_o), 32'(seen + 1));
            if (seen > 0) chk("all_spacing", 32'(c - last), 3);
            last = c;
            seen++;
         end
      end
      chk("all_count", 32'(seen), 18);
      chk("all_busy_end", 32'(busy_o), 0);
      chk("all_pending_end", 32'(pending_o), 0);

      // Code 7 held under backpressure; other requests arrive meanwhile
      data_rdy_i = 1'b0;
      req_i      = 18'h00040;
      tick();
      req_i = '0;
      tick();
      chk("hold_val_first", 32'(data_val_o), 1);
      chk("hold_data_first", 32'(data_o), 7);
      req_i = 18'h00204;
      tick();
      req_i = '0;
      chk("hold_data", 32'(data_o), 7);
      for (int i = 0; i < 9; i++) begin
         tick();
         chk("hold_data", 32'(data_o), 7);
         chk("hold_val", 32'(data_val_o), 1);
      end
      chk("hold_pending", 32'(pending_o), 32'h244);

      // Re-request bit 6 in its own transfer cycle
      data_rdy_i = 1'b1;
      req_i      = 18'h00040;
      tick();
      req_i = '0;
      chk("rereq_val_drop", 32'(data_val_o), 0);
      chk("rereq_pending", 32'(pending_o), 32'h244);
      seen = 0;
      for (int c = 0; c < 15; c++) begin
         tick();
         if (data_val_o) begin
            if (seen < 3) chk("rereq_order", 32'(data_o), 32'(exp3[seen]));
            seen++;
         end
      end
      chk("rereq_count", 32'(seen), 3);
      chk("rereq_busy_end", 32'(busy_o), 0);

      // Flush during offer of code 10 with bits 2 and 9 pending
      data_rdy_i = 1'b0;
      req_i      = 18'h00204;
      tick();
      req_i = '0;
      tick();
      chk("flush_pre_data", 32'(data_o), 10);
      flush_i    = 1'b1;
      data_rdy_i = 1'b1;
      tick();
      flush_i = 1'b0;
      chk("flush_val", 32'(data_val_o), 0);
      chk("flush_data", 32'(data_o), 0);
      chk("flush_pending", 32'(pending_o), 0);
      chk("flush_busy", 32'(busy_o), 0);
      tick();
      chk("flush_stays_idle", 32'(data_val_o), 0);
      // Pointer untouched by the flush: code 10 comes first again
      req_i = 18'h00204;
      tick();
      req_i = '0;
      tick();
      chk("flush_ptr_kept", 32'(data_o), 10);
      for (int i = 0; i < 8; i++) tick();
      chk("flush_drained", 32'(busy_o), 0);

      // Asynchronous reset in the middle of an offer
      data_rdy_i = 1'b0;
      req_i      = 18'h00020;
      tick();
      req_i = '0;
      tick();
      chk("arst_pre_data", 32'(data_o), 6);
      chk("arst_pre_val", 32'(data_val_o), 1);
      #3;
      rst_n_i = 1'b0;
      #1;
      chk("arst_val", 32'(data_val_o), 0);
      chk("arst_data", 32'(data_o), 0);
      chk("arst_pending", 32'(pending_o), 0);
      chk("arst_busy", 32'(busy_o), 0);
      tick();
      rst_n_i    = 1'b1;
      data_rdy_i = 1'b1;
      req_i      = 18'h00001;
      tick();
      req_i = '0;
      chk("arst_after_val_early", 32'(data_val_o), 0);
      tick();
      chk("arst_after_val", 32'(data_val_o), 1);
      chk("arst_after_data", 32'(data_o), 1);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
